dmem_responder: RTL and testbench

- Multi-cycle data-memory responder at the slave end of the memory-stage load/store interface.
- Accepts one read or write request (word or byte) from the memory stage, holds it for a fixed access latency, then commits the write or returns read data.
- Drives a stall signal that freezes the pipeline flip-flops while an access is outstanding.
- Replaces the single-cycle data array behind the memory stage.

---
 rtl/dmem_responder_if.sv | 39 +++
 rtl/dmem_responder.sv | 170 +++++++++++++++++
 tb/tb_dmem_responder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - memory-stage load/store request/response bundle
interface dmem_responder_if;
  logic        req_valid;
  logic        req_write;
  logic        req_word;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;

  modport master (
    output req_valid,
    output req_write,
    output req_word,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata,
    input  resp_err,
    input  stall
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_word,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output resp_valid,
    output resp_rdata,
    output resp_err,
    output stall
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder with pipeline stall
// One access in flight; the array is committed/read on the edge entering RESP.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic             clock,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic        lat_write_q, lat_write_d;
  logic        lat_word_q, lat_word_d;
  logic [31:0] lat_addr_q, lat_addr_d;
  logic [31:0] lat_wdata_q, lat_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic        enter_resp;
  logic        acc_write;
  logic        acc_word;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [AW-1:0] acc_idx;
  logic [1:0]  acc_lane;
  logic        acc_oor;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [31:0] load_data;
  logic        write_en;

  logic [31:0] mem [DEPTH_WORDS];

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    lat_write_d = lat_write_q;
    lat_word_d  = lat_word_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    enter_resp  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          lat_write_d = bus.req_write;
          lat_word_d  = bus.req_word;
          lat_addr_d  = bus.req_addr;
          lat_wdata_d = bus.req_wdata;
          count_d     = CNT_INIT;
          if (LATENCY == 1) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // With LATENCY=1 the access commits on the accepting edge, before the latch holds it.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_write = bus.req_write;
      acc_word  = bus.req_word;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
    end else begin
      acc_write = lat_write_q;
      acc_word  = lat_word_q;
      acc_addr  = lat_addr_q;
      acc_wdata = lat_wdata_q;
    end
  end

  assign acc_idx  = acc_addr[AW+1:2];
  assign acc_lane = acc_addr[1:0];
  assign acc_oor  = |acc_addr[31:AW+2];
  assign rd_word  = mem[acc_idx];

  always_comb begin
    case (acc_lane)
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
  end

  assign load_data = acc_word ? rd_word : {24'd0, rd_byte};
  assign write_en  = enter_resp & acc_write & ~acc_oor & rst;

  always_comb begin
    resp_valid_d = enter_resp;
    resp_err_d   = enter_resp & acc_oor;
    resp_rdata_d = resp_rdata_q;
    if (enter_resp) begin
      resp_rdata_d = (acc_oor || acc_write) ? 32'd0 : load_data;
    end
  end

  always_ff @(posedge clock) begin
    if (write_en) begin
      if (acc_word) begin
        mem[acc_idx] <= acc_wdata;
      end else begin
        case (acc_lane)
          2'd0:    mem[acc_idx][7:0]   <= acc_wdata[7:0];
          2'd1:    mem[acc_idx][15:8]  <= acc_wdata[7:0];
          2'd2:    mem[acc_idx][23:16] <= acc_wdata[7:0];
          default: mem[acc_idx][31:24] <= acc_wdata[7:0];
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      count_q      <= 4'd0;
      lat_write_q  <= 1'b0;
      lat_word_q   <= 1'b0;
      lat_addr_q   <= 32'd0;
      lat_wdata_q  <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      lat_write_q  <= lat_write_d;
      lat_word_q   <= lat_word_d;
      lat_addr_q   <= lat_addr_d;
      lat_wdata_q  <= lat_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // The pipeline is released in RESP so it advances on the edge that leaves RESP.
  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.stall      = ((state_q == S_IDLE) && bus.req_valid) || (state_q == S_WAIT);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed vector bench for dmem_responder
module tb_dmem_responder;

  logic clock;
  logic rst;
  int   checks;
  int   errors;

  dmem_responder_if bus3();
  dmem_responder_if bus1();

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) u_dut3 (
    .clock (clock),
    .rst   (rst),
    .bus   (bus3)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
    .clock (clock),
    .rst   (rst),
    .bus   (bus1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        write;
    logic        word;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    bus3.req_write = v.write;
    bus3.req_word  = v.word;
    bus3.req_addr  = v.addr;
    bus3.req_wdata = v.wdata;
    bus3.req_valid = 1'b1;
    #2;
    chk($sformatf("v%0d idle ready", idx), 32'(bus3.req_ready), 32'd1);
    chk($sformatf("v%0d idle stall", idx), 32'(bus3.stall), 32'd1);
    @(posedge clock);
    #1;
    bus3.req_valid = 1'b0;
    bus3.req_addr  = 32'hFFFF_FFFF;
    n = 0;
    forever begin
      @(negedge clock);
      n++;
      if (bus3.resp_valid === 1'b1) break;
      chk($sformatf("v%0d wait stall", idx), 32'(bus3.stall), 32'd1);
      if (n >= 30) begin
        chk($sformatf("v%0d resp timeout", idx), 32'(n), 32'd3);
        return;
      end
    end
    chk($sformatf("v%0d latency", idx), 32'(n), 32'd3);
    chk($sformatf("v%0d rdata", idx), bus3.resp_rdata, v.exp_rdata);
    chk($sformatf("v%0d err", idx), 32'(bus3.resp_err), 32'(v.exp_err));
    chk($sformatf("v%0d resp ready", idx), 32'(bus3.req_ready), 32'd0);
    chk($sformatf("v%0d resp stall", idx), 32'(bus3.stall), 32'd0);
    @(negedge clock);
    chk($sformatf("v%0d pulse", idx), 32'(bus3.resp_valid), 32'd0);
    chk($sformatf("v%0d hold rdata", idx), bus3.resp_rdata, v.exp_rdata);
    chk($sformatf("v%0d err clear", idx), 32'(bus3.resp_err), 32'd0);
  endtask

  initial begin
    int nresp;
    checks = 0;
    errors = 0;

    vecs[0]  = '{1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0011, 32'hFFFF_FFA5, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_A5EF, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0000_0011, 32'h0000_0000, 32'h0000_00A5, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0000_0013, 32'h0000_0000, 32'h0000_00DE, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_0013, 32'h0000_0000, 32'hDEAD_A5EF, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 32'h0000_0000, 32'h0102_0304, 32'h0000_0000, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0102_0304, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'h0000_0404, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 32'h0000_03FC, 32'h1122_3344, 32'h0000_0000, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 32'h0000_03FE, 32'h0000_0000, 32'h0000_0022, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[14] = '{1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};

    bus3.req_valid = 1'b0; bus3.req_write = 1'b0; bus3.req_word = 1'b0;
    bus3.req_addr  = 32'd0; bus3.req_wdata = 32'd0;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_word = 1'b1;
    bus1.req_addr  = 32'd0; bus1.req_wdata = 32'd0;
    rst = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst ready", 32'(bus3.req_ready), 32'd1);
    chk("rst resp_valid", 32'(bus3.resp_valid), 32'd0);
    chk("rst rdata", bus3.resp_rdata, 32'd0);
    chk("rst err", 32'(bus3.resp_err), 32'd0);
    chk("rst stall", 32'(bus3.stall), 32'd0);
    rst = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 0; i < 15; i++) begin
      run_vec(vecs[i], i);
    end

    // Reset one cycle after acceptance: the store to 0x20 must be dropped.
    @(posedge clock);
    #1;
    bus3.req_write = 1'b1; bus3.req_word = 1'b1;
    bus3.req_addr  = 32'h0000_0020; bus3.req_wdata = 32'h1234_5678;
    bus3.req_valid = 1'b1;
    @(posedge clock);
    #1;
    bus3.req_valid = 1'b0;
    chk("abort in wait", 32'(bus3.req_ready), 32'd0);
    rst = 1'b0;
    nresp = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      if (bus3.resp_valid === 1'b1) nresp++;
    end
    chk("abort rdata", bus3.resp_rdata, 32'd0);
    chk("abort ready", 32'(bus3.req_ready), 32'd1);
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (bus3.resp_valid === 1'b1) nresp++;
    end
    chk("abort no resp", 32'(nresp), 32'd0);
    run_vec('{1'b0, 1'b1, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, 1'b0}, 20);

    // LATENCY=1: one store, then four loads with req_valid held high.
    @(posedge clock);
    #1;
    bus1.req_write = 1'b1; bus1.req_addr = 32'h0000_0000; bus1.req_wdata = 32'h0BAD_F00D;
    bus1.req_valid = 1'b1;
    @(posedge clock);
    #1;
    bus1.req_valid = 1'b0;
    bus1.req_write = 1'b0;
    @(negedge clock);
    chk("l1 store resp", 32'(bus1.resp_valid), 32'd1);
    @(posedge clock);
    #1;
    bus1.req_valid = 1'b1;
    nresp = 0;
    for (int c = 0; c < 11; c++) begin
      @(negedge clock);
      if (c == 7) bus1.req_valid = 1'b0;
      if (bus1.resp_valid === 1'b1) begin
        nresp++;
        chk($sformatf("l1 rdata c%0d", c), bus1.resp_rdata, 32'h0BAD_F00D);
      end
      if (c < 8) begin
        chk($sformatf("l1 valid c%0d", c), 32'(bus1.resp_valid), 32'(c % 2));
        chk($sformatf("l1 ready c%0d", c), 32'(bus1.req_ready), 32'((c + 1) % 2));
      end
    end
    chk("l1 responses", 32'(nresp), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
